// File: rtl/qupls4_preg_free_scheduler.sv
// Merges commit frees and flush-bitmap drains onto the four supplier free slots.
// Define QUPLS4_FREE_ANTISTARVE_EN to let a starved drain stall commit frees.
module qupls4_preg_free_scheduler #(
   parameter int PREGS = 512,
   parameter int STARVE_LIM = 8
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [3:0][$clog2(PREGS)-1:0]  cmt_tags,
   input  logic [3:0]                     cmt_vals,
   input  logic                           flush_load,
   input  logic [PREGS-1:0]               flush_list,
   input  logic                           abort,
   output logic [3:0][$clog2(PREGS)-1:0]  tags2free,
   output logic [3:0]                     freevals,
   output logic                           busy,
   output logic                           flush_done,
   output logic                           cmt_stall
);

   localparam int TW = $clog2(PREGS);
   localparam int Q = PREGS / 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t state;
   logic [PREGS-1:0] pending;
   logic [PREGS-1:0] cmt_mask;
   logic [PREGS-1:0] eff;
   logic [PREGS-1:0] scan_mask;
   logic [PREGS-1:0] pending_next;
   logic [3:0][TW-1:0] sel_tags;
   logic [3:0] sel_vals;
   logic stall;
   logic load_nz;

   assign load_nz = flush_load && (|flush_list);
   assign busy = rst && ((|pending) || flush_load);
   assign cmt_stall = stall;

   // Commit tags are masked out before scanning so a bit is never freed twice.
   always_comb begin
      logic found;
      logic [TW-1:0] idx;
      cmt_mask = '0;
      scan_mask = '0;
      sel_tags = '0;
      sel_vals = '0;
      found = 1'b0;
      idx = '0;
      for (int k = 0; k < 4; k++)
         if (cmt_vals[k] && !stall)
            cmt_mask[cmt_tags[k]] = 1'b1;
      eff = pending & ~cmt_mask;
      for (int k = 0; k < 4; k++) begin
         if (cmt_vals[k] && !stall) begin
            sel_tags[k] = cmt_tags[k];
            sel_vals[k] = 1'b1;
         end else begin
            found = 1'b0;
            idx = '0;
            for (int i = Q - 1; i >= 0; i--)
               if (eff[k*Q+i]) begin
                  found = 1'b1;
                  idx = TW'(k*Q+i);
               end
            if (found) begin
               sel_tags[k] = idx;
               sel_vals[k] = 1'b1;
               scan_mask[idx] = 1'b1;
            end
         end
      end
      pending_next = (pending & ~(cmt_mask | scan_mask))
                   | (flush_load ? flush_list : '0);
   end

`ifdef QUPLS4_FREE_ANTISTARVE_EN
   localparam int CW = $clog2(STARVE_LIM + 1);
   logic [CW-1:0] starve_cnt;
   logic sat;

   assign sat = (|pending) && (&cmt_vals) && !stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
         stall <= 1'b0;
      end else if (sat) begin
         if (starve_cnt == CW'(STARVE_LIM - 1)) begin
            starve_cnt <= '0;
            stall <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + 1'b1;
            stall <= 1'b0;
         end
      end else begin
         starve_cnt <= '0;
         stall <= 1'b0;
      end
   end
`else
   assign stall = (STARVE_LIM < 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
         state <= IDLE;
         tags2free <= '0;
         freevals <= '0;
         flush_done <= 1'b0;
      end else begin
         tags2free <= sel_tags;
         freevals <= sel_vals;
         flush_done <= (state == DONE);
         pending <= abort ? '0 : pending_next;
         unique case (state)
            IDLE:
               if (!abort && load_nz)
                  state <= SCAN;
            SCAN:
               if (abort)
                  state <= IDLE;
               else if (pending_next == '0)
                  state <= DONE;
            DONE:
               if (!abort && load_nz)
                  state <= SCAN;
               else
                  state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qupls4_preg_free_scheduler.sv
// Directed and random checks of the free scheduler against a set-based model.
module tb_qupls4_preg_free_scheduler;

   localparam int PREGS = 512;
   localparam int TW = 9;
   localparam int Q = PREGS / 4;
   localparam int LIM = 8;

   logic clk = 1'b0;
   logic rst;
   logic [3:0][TW-1:0] cmt_tags;
   logic [3:0] cmt_vals;
   logic flush_load;
   logic [PREGS-1:0] flush_list;
   logic abort;
   logic [3:0][TW-1:0] tags2free;
   logic [3:0] freevals;
   logic busy;
   logic flush_done;
   logic cmt_stall;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   bit mp[PREGS];
   bit m_active;
   bit m_arm;
   bit m_stall;
   int m_cnt;
   logic [3:0][TW-1:0] e_tags;
   logic [3:0] e_vals;
   logic e_fd;
   logic e_stall;

   qupls4_preg_free_scheduler #(.PREGS(PREGS), .STARVE_LIM(LIM)) dut (
      .clk(clk),
      .rst(rst),
      .cmt_tags(cmt_tags),
      .cmt_vals(cmt_vals),
      .flush_load(flush_load),
      .flush_list(flush_list),
      .abort(abort),
      .tags2free(tags2free),
      .freevals(freevals),
      .busy(busy),
      .flush_done(flush_done),
      .cmt_stall(cmt_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit any_pend();
      for (int i = 0; i < PREGS; i++)
         if (mp[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      bit clr[PREGS];
      bit st;
      bit anyp;
      bit sat;
      if (!rst) begin
         for (int i = 0; i < PREGS; i++) mp[i] = 1'b0;
         m_active = 0; m_arm = 0; m_stall = 0; m_cnt = 0;
         e_tags = '0; e_vals = '0; e_fd = 1'b0; e_stall = 1'b0;
         return;
      end
      st = m_stall;
      anyp = any_pend();
      for (int i = 0; i < PREGS; i++) clr[i] = 1'b0;
      e_tags = '0;
      e_vals = '0;
      for (int k = 0; k < 4; k++)
         if (cmt_vals[k] && !st) begin
            e_tags[k] = cmt_tags[k];
            e_vals[k] = 1'b1;
            clr[cmt_tags[k]] = 1'b1;
         end
      for (int k = 0; k < 4; k++)
         if (!e_vals[k])
            for (int i = k * Q; i < (k + 1) * Q; i++)
               if (mp[i] && !clr[i]) begin
                  e_tags[k] = TW'(i);
                  e_vals[k] = 1'b1;
                  clr[i] = 1'b1;
                  break;
               end
      e_fd = m_arm;
      m_arm = 0;
      if (abort) begin
         for (int i = 0; i < PREGS; i++) mp[i] = 1'b0;
         m_active = 0;
      end else begin
         for (int i = 0; i < PREGS; i++)
            mp[i] = (mp[i] && !clr[i]) || (flush_load && flush_list[i]);
         if (flush_load && (|flush_list)) m_active = 1;
         if (m_active && !any_pend()) begin
            m_arm = 1;
            m_active = 0;
         end
      end
`ifdef QUPLS4_FREE_ANTISTARVE_EN
      sat = anyp && (&cmt_vals) && !st;
      if (sat && m_cnt == LIM - 1) begin
         m_cnt = 0; m_stall = 1;
      end else if (sat) begin
         m_cnt++; m_stall = 0;
      end else begin
         m_cnt = 0; m_stall = 0;
      end
`else
      sat = anyp && 1'b0;
      m_stall = sat;
`endif
      e_stall = m_stall;
   endtask

   task automatic step();
      @(negedge clk);
      chk("busy", 64'(busy), 64'(rst && (any_pend() || flush_load)));
      model_edge();
      @(posedge clk);
      #1;
      chk("freevals", 64'(freevals), 64'(e_vals));
      chk("tags2free", 64'(tags2free), 64'(e_tags));
      chk("flush_done", 64'(flush_done), 64'(e_fd));
      chk("cmt_stall", 64'(cmt_stall), 64'(e_stall));
   endtask

   task automatic idle_in();
      cmt_vals = '0;
      cmt_tags = '0;
      flush_load = 1'b0;
      flush_list = '0;
      abort = 1'b0;
   endtask

   initial begin
      int cnt;
      int fd_seen;
      int stall_at;
      int q;
      idle_in();
      rst = 1'b0;
      flush_load = 1'b1;
      flush_list = '1;
      step();
      step();
      chk("rst_freevals", 64'(freevals), 64'h0);
      rst = 1'b1;
      idle_in();
      step();
      chk("rst_busy", 64'(busy), 64'h0);

      flush_load = 1'b1;
      flush_list[3] = 1'b1;
      flush_list[130] = 1'b1;
      flush_list[260] = 1'b1;
      flush_list[400] = 1'b1;
      step();
      idle_in();
      step();
      chk("drain_vals", 64'(freevals), 64'hF);
      chk("drain_tags", 64'(tags2free),
          64'({9'd400, 9'd260, 9'd130, 9'd3}));
      step();
      chk("drain_done", 64'(flush_done), 64'h1);

      flush_load = 1'b1;
      flush_list[5] = 1'b1;
      flush_list[6] = 1'b1;
      step();
      idle_in();
      cmt_vals = 4'b0001;
      cmt_tags[0] = 9'd77;
      step();
      idle_in();
      chk("prio_tag", 64'(tags2free[0]), 64'd77);
      chk("prio_vals", 64'(freevals), 64'h1);
      step();
      chk("prio_t5", 64'(tags2free[0]), 64'd5);
      step();
      chk("prio_t6", 64'(tags2free[0]), 64'd6);
      chk("prio_nodone", 64'(flush_done), 64'h0);
      step();
      chk("prio_done", 64'(flush_done), 64'h1);

      flush_load = 1'b1;
      flush_list[10] = 1'b1;
      step();
      idle_in();
      cmt_vals = 4'b0010;
      cmt_tags[1] = 9'd10;
      cnt = 0;
      for (int s = 0; s < 4; s++) begin
         step();
         idle_in();
         for (int k = 0; k < 4; k++)
            if (freevals[k] && tags2free[k] == 9'd10) cnt++;
      end
      chk("dfree_once", 64'(cnt), 64'd1);

      flush_load = 1'b1;
      for (int i = 256; i < 276; i++) flush_list[i] = 1'b1;
      step();
      idle_in();
      for (int s = 0; s < 5; s++) step();
      abort = 1'b1;
      step();
      idle_in();
      chk("abort_busy", 64'(busy), 64'h0);
      fd_seen = 0;
      for (int s = 0; s < 3; s++) begin
         step();
         if (flush_done) fd_seen++;
      end
      chk("abort_nodone", 64'(fd_seen), 64'd0);

`ifdef QUPLS4_FREE_ANTISTARVE_EN
      flush_load = 1'b1;
      flush_list[500] = 1'b1;
      step();
      idle_in();
      cmt_vals = 4'hF;
      cmt_tags = {9'd4, 9'd3, 9'd2, 9'd1};
      stall_at = 0;
      for (int s = 1; s <= 12; s++) begin
         step();
         if (cmt_stall && stall_at == 0) stall_at = s;
         if (stall_at != 0) break;
      end
      chk("stall_cycle", 64'(stall_at), 64'd8);
      step();
      chk("stall_slot3", 64'(tags2free[3]), 64'd500);
      chk("stall_vals3", 64'(freevals[3]), 64'h1);
      idle_in();
      abort = 1'b1;
      step();
      idle_in();
`else
      stall_at = 0;
`endif

      for (int c = 0; c < 600; c++) begin
         idle_in();
         for (int k = 0; k < 4; k++) begin
            cmt_vals[k] = ($urandom_range(0, 2) == 0);
            cmt_tags[k] = TW'($urandom_range(0, PREGS - 1));
         end
         if ($urandom_range(0, 15) == 0) cmt_vals = 4'hF;
         if ($urandom_range(0, 9) == 0) begin
            flush_load = 1'b1;
            q = $urandom_range(0, 3);
            for (int i = 0; i < Q; i++)
               if ($urandom_range(0, 7) == 0) flush_list[q*Q+i] = 1'b1;
            if ($urandom_range(0, 1) == 1)
               for (int i = 0; i < PREGS; i++)
                  if ($urandom_range(0, 63) == 0) flush_list[i] = 1'b1;
         end
         abort = ($urandom_range(0, 39) == 0);
         step();
      end
      idle_in();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/qupls4_preg_free_scheduler.md
Name: qupls4_preg_free_scheduler

Overview:
- Sequences all physical-register frees into the register name supplier's NFTAGS=4 free port (tags2free/freevals).
- Sources: per-clock commit frees, plus bulk frees from a pipeline flush (a bitmap of squashed destination registers).
- Commit frees always win a slot. Flush frees drain through the unused slots, one register per slot per clock, from a pending bitmap partitioned into four quarters that match the supplier's bitmap partitioning.

Parameters:
- PREGS, 512, number of physical registers (128/256/512); quarter size Q = PREGS/4.
- STARVE_LIM, 8, commit-saturated cycles tolerated before forcing a drain (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- cmt_tags  in  4 x $clog2(PREGS)  committed tags to free, slot k
- cmt_vals  in  4  valid per commit slot
- flush_load  in  1  pulse: OR flush_list into pending bitmap
- flush_list  in  PREGS  registers to free due to squash
- abort  in  1  discard pending bitmap (checkpoint restore supersedes)
- tags2free  out  4 x $clog2(PREGS)  to supplier
- freevals  out  4  to supplier
- busy  out  1  pending bitmap non-zero, or flush_load this cycle
- flush_done  out  1  one-cycle pulse when drain completes
- cmt_stall  out  1  commit must hold frees this cycle (optional feature; else 0)

Behaviour:
- Reset (rst==0 at clk edge): pending=0, state=IDLE, tags2free=0, freevals=0, busy=0, flush_done=0, cmt_stall=0, starve counter=0.
- Outputs are registered: a request in cycle N appears on tags2free/freevals in cycle N+1.
- Slot k selection, per cycle:
  - If cmt_vals[k]: emit cmt_tags[k]; also clear that tag's bit in pending (no double free).
  - Else if quarter k of pending (bits [k*Q +: Q]) is non-zero: emit the lowest set bit in quarter k and clear it.
  - Else: freevals[k]=0.
- Commit tag outside quarter k is legal: it is emitted unchanged, and its pending bit is cleared wherever it lies.
- pending_next = (pending & ~cleared_bits) | (flush_load ? flush_list : 0).
  - A bit cleared and reloaded in the same cycle ends up set (load wins).
  - Newly loaded bits are not eligible until the next cycle.
- abort clears pending next cycle, with priority over flush_load and scan. Grants already selected this cycle still issue. flush_done is not pulsed on abort.
- FSM:
  - IDLE -> SCAN on flush_load with non-zero flush_list.
  - SCAN -> DONE when pending_next==0 (and no abort).
  - SCAN -> IDLE on abort.
  - DONE: flush_done=1 for one cycle, then IDLE; a flush_load in DONE goes to SCAN.
  - flush_load while in SCAN merges into pending; state stays SCAN.
- flush_done is asserted in the cycle after the final pending bit is emitted on freevals.
- busy = (pending!=0) | flush_load, combinational.
- Worst-case drain: Q cycles with no commit traffic (all bits set in one quarter).

Optional Feature:
- Macro QUPLS4_FREE_ANTISTARVE_EN.
- Enabled:
  - Counter increments each cycle pending!=0 and all four cmt_vals are set; resets otherwise.
  - At count==STARVE_LIM: cmt_stall=1 for one cycle and the counter clears.
  - In a cmt_stall cycle, cmt_vals is ignored: all four slots drain pending and no commit pending-bit clear occurs.
  - Upstream retains and re-presents its frees next cycle.
- Disabled: no counter, cmt_stall tied 0; flush drain may starve indefinitely.

Test Plan:
- Reset: rst=0 two cycles with flush_load=1 -> all outputs 0, pending 0; after release, busy=0.
- Basic drain: flush_load with bits {3,130,260,400} set, PREGS=512, no commits -> next cycle freevals=4'hF with tags 3,130,260,400; flush_done pulses the following cycle.
- Commit priority: pending bits {5,6} in quarter 0; cmt_vals=4'b0001, tag 77 -> cycle outputs slot0=77. Bits 5 and 6 emit on later cycles, one per cycle; flush_done follows the cycle after tag 6 issues.
- Double-free guard: pending bit 10 set, commit slot1 frees tag 10 -> tag 10 appears exactly once on tags2free over the whole drain.
- Abort mid-drain: quarter 2 loaded with 20 bits, abort after 5 cycles -> pending 0 next cycle, no flush_done, busy=0.
- Anti-starve (macro on, STARVE_LIM=8): pending bit 500 set, cmt_vals=4'hF continuously -> cmt_stall=1 on cycle 8; tag 500 emitted on slot 3 the next cycle; counter restarts.
